// File: rtl/conv_mac_engine.sv
// Multi-cycle signed dot product of a KERNEL_SIZE^2 window using LANES multipliers per pass.
// Optional CONV_SAT_EN clamps out-of-range results instead of wrapping them.
module conv_mac_engine #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned LANES       = 3,
  parameter int unsigned FRAC_BITS   = 0,
  parameter int unsigned ACC_WIDTH   = 2*DATA_WIDTH + $clog2(KERNEL_SIZE*KERNEL_SIZE)
) (
  input  logic                                          Clk,
  input  logic                                          Rst,
  input  logic                                          mStart,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] multiplier_input,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] multiplicand_input,
  output logic                                          busy,
  output logic signed [DATA_WIDTH-1:0]                  finalAccumulate,
  output logic                                          finalReady,
  output logic                                          overflow
);

  localparam int unsigned N      = KERNEL_SIZE*KERNEL_SIZE;
  localparam int unsigned PASSES = (N + LANES - 1) / LANES;
  localparam int unsigned PAD_N  = PASSES*LANES;
  localparam int unsigned WIN_W  = N*DATA_WIDTH;
  localparam int unsigned PAD_W  = PAD_N*DATA_WIDTH;
  localparam int unsigned IDX_W  = $clog2(PAD_N + 1);
  localparam int unsigned PROD_W = 2*DATA_WIDTH;
  localparam int unsigned HI_W   = ACC_WIDTH - DATA_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, MAC, FINAL} stateT;

  stateT                        state;
  logic [WIN_W-1:0]             winA;
  logic [WIN_W-1:0]             winB;
  logic [PAD_W-1:0]             padA;
  logic [PAD_W-1:0]             padB;
  logic [IDX_W-1:0]             idx;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  passSum;
  logic signed [ACC_WIDTH-1:0]  res;
  logic signed [DATA_WIDTH-1:0] laneA [LANES];
  logic signed [DATA_WIDTH-1:0] laneB [LANES];
  logic signed [PROD_W-1:0]     laneProd [LANES];
  logic [HI_W-1:0]              resHi;
  logic                         resOvf;
  logic [DATA_WIDTH-1:0]        resOut;
  logic                         lastPass;

  // Zero-extended windows so padding lanes past N multiply by zero
  assign padA = PAD_W'(winA);
  assign padB = PAD_W'(winB);

  // Lane operand select for the current pass and the pass partial sum
  always_comb begin
    passSum = '0;
    for (int l = 0; l < LANES; l++) begin
      laneA[l] = '0;
      laneB[l] = '0;
      for (int p = 0; p < PASSES; p++) begin
        if (idx == IDX_W'(p*LANES)) begin
          laneA[l] = padA[(p*LANES + l)*DATA_WIDTH +: DATA_WIDTH];
          laneB[l] = padB[(p*LANES + l)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      laneProd[l] = PROD_W'(laneA[l]) * PROD_W'(laneB[l]);
      passSum     = passSum + ACC_WIDTH'(laneProd[l]);
    end
  end

  assign lastPass = (idx + IDX_W'(LANES)) >= IDX_W'(N);

  // Result scaling and range check: res fits iff its top HI_W bits are all equal
  always_comb begin
    res    = acc >>> FRAC_BITS;
    resHi  = res[ACC_WIDTH-1 -: HI_W];
    resOvf = !((&resHi) || !(|resHi));
`ifdef CONV_SAT_EN
    if (resOvf) begin
      resOut = res[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      resOut = res[DATA_WIDTH-1:0];
    end
`else
    resOut = res[DATA_WIDTH-1:0];
`endif
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state           <= IDLE;
      winA            <= '0;
      winB            <= '0;
      idx             <= '0;
      acc             <= '0;
      busy            <= 1'b0;
      finalAccumulate <= '0;
      finalReady      <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      finalReady <= 1'b0;
      case (state)
        IDLE: begin
          if (mStart) begin
            winA  <= multiplier_input;
            winB  <= multiplicand_input;
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + passSum;
          idx <= idx + IDX_W'(LANES);
          if (lastPass) state <= FINAL;
        end
        FINAL: begin
          finalAccumulate <= resOut;
          overflow        <= resOvf;
          finalReady      <= 1'b1;
          busy            <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
